// File: rtl/pooled_feature_serializer.sv
// Buffers one pooled feature map per kernel from a lane-multiplexed input,
// then replays every map as one valid/ready pixel stream, channel-major and
// raster order within a channel.
module pooled_feature_serializer #(
    parameter int BitSize            = 32,
    parameter int NumberOfK          = 4,
    parameter int ProcessingElements = 2,
    parameter int PooledWidth        = 2,
    localparam int ChW               = (NumberOfK > 1) ? $clog2(NumberOfK) : 1
) (
    input  logic                                         clk,
    input  logic                                         res_n,
    input  logic [NumberOfK-1:0]                         in_valid,
    input  logic [ProcessingElements-1:0][BitSize-1:0]   in_data,
    output logic                                         in_ready,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [BitSize-1:0]                           out_data,
    output logic [ChW-1:0]                               out_channel,
    output logic                                         out_last,
    output logic                                         out_done,
    output logic                                         overflow
);
    localparam int Depth = PooledWidth * PooledWidth;
    localparam int IdxW  = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int CntW  = $clog2(Depth + 1);

    localparam logic [CntW-1:0] DepthC   = CntW'(Depth);
    localparam logic [IdxW-1:0] IdxLast  = IdxW'(Depth - 1);
    localparam logic [ChW-1:0]  ChLast   = ChW'(NumberOfK - 1);

    typedef enum logic [1:0] {S_COLLECT, S_DRAIN, S_DONE} state_t;

    state_t                          r_state;
    logic [BitSize-1:0]              r_mem [NumberOfK][Depth];
    logic [NumberOfK-1:0][CntW-1:0]  r_wcnt;
    logic [ChW-1:0]                  r_rch;
    logic [IdxW-1:0]                 r_ridx;
    logic                            r_overflow;

    logic [NumberOfK-1:0]            w_we;
    logic [NumberOfK-1:0]            w_drop;
    logic                            w_all_full;

    // Per-kernel write enables; anything valid but not written is a drop.
    always_comb begin
        w_we       = '0;
        w_all_full = 1'b1;
        for (int i = 0; i < NumberOfK; i++) begin
            w_we[i] = (r_state == S_COLLECT) && in_valid[i] && (r_wcnt[i] != DepthC);
            if (r_wcnt[i] != DepthC) w_all_full = 1'b0;
        end
        w_drop = in_valid & ~w_we;
    end

    // Pixel storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NumberOfK; i++) begin
            if (w_we[i]) r_mem[i][r_wcnt[i][IdxW-1:0]] <= in_data[i % ProcessingElements];
        end
    end

    // Collect/drain/done sequencing with write counters and read pointers.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state    <= S_COLLECT;
            r_wcnt     <= '0;
            r_rch      <= '0;
            r_ridx     <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (|w_drop) r_overflow <= 1'b1;
            case (r_state)
                S_COLLECT: begin
                    for (int i = 0; i < NumberOfK; i++) begin
                        if (w_we[i]) r_wcnt[i] <= r_wcnt[i] + CntW'(1);
                    end
                    // Decided on registered counts, so the transition costs one
                    // cycle after the final capture.
                    if (w_all_full) begin
                        r_state <= S_DRAIN;
                        r_rch   <= '0;
                        r_ridx  <= '0;
                    end
                end
                S_DRAIN: begin
                    if (out_ready) begin
                        if (r_ridx != IdxLast) begin
                            r_ridx <= r_ridx + IdxW'(1);
                        end else begin
                            r_ridx <= '0;
                            r_rch  <= r_rch + ChW'(1);
                            if (r_rch == ChLast) r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_wcnt  <= '0;
                    r_rch   <= '0;
                    r_ridx  <= '0;
                    r_state <= S_COLLECT;
                end
                default: r_state <= S_COLLECT;
            endcase
        end
    end

    // Outputs decode directly from registered state and pointers.
    assign in_ready    = (r_state == S_COLLECT);
    assign out_valid   = (r_state == S_DRAIN);
    assign out_data    = out_valid ? r_mem[r_rch][r_ridx] : '0;
    assign out_channel = out_valid ? r_rch : '0;
    assign out_last    = out_valid && (r_ridx == IdxLast);
    assign out_done    = (r_state == S_DONE);
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_pooled_feature_serializer.sv
// Randomized bench for pooled_feature_serializer with a queue-based model:
// each kernel keeps a queue of accepted pixels, the drain is the
// concatenation of those queues in kernel order.
module tb_pooled_feature_serializer;
    localparam int BS = 32;
    localparam int K  = 4;
    localparam int PE = 2;
    localparam int PW = 2;
    localparam int D  = PW * PW;
    localparam int CW = 2;

    logic                   clk = 1'b0;
    logic                   res_n = 1'b0;
    logic [K-1:0]           in_valid = '0;
    logic [PE-1:0][BS-1:0]  in_data = '0;
    logic                   in_ready;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [BS-1:0]          out_data;
    logic [CW-1:0]          out_channel;
    logic                   out_last;
    logic                   out_done;
    logic                   overflow;

    pooled_feature_serializer #(
        .BitSize(BS), .NumberOfK(K), .ProcessingElements(PE), .PooledWidth(PW)
    ) dut (
        .clk(clk), .res_n(res_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_channel(out_channel), .out_last(out_last), .out_done(out_done),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    int unsigned mdl [K][$];
    bit          ovf_exp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < K; k++) mdl[k].delete();
    endtask

    // mode 0: reference pattern 16*k+p, kernels 0/1 then 2/3
    // mode 1: random pixels, only to kernels still short of a full map
    // mode 2: reference pattern plus a 5th pixel to kernel 1
    task automatic load(input int mode);
        int           cyc;
        bit           full;
        int           p;
        logic [K-1:0] v;
        logic [K-1:0] notfull;
        cyc  = 0;
        full = 1'b0;
        while (!full && cyc < 1000) begin
            @(negedge clk);
            chk("ld_in_ready", in_ready, 1);
            chk("ld_out_valid", out_valid, 0);
            chk("ld_out_data_zero", out_data, 0);
            if (mode == 1) begin
                for (int k = 0; k < K; k++) notfull[k] = (mdl[k].size() < D);
                v = K'($urandom) & notfull;
                for (int l = 0; l < PE; l++) in_data[l] = $urandom;
            end else begin
                p = cyc % 4;
                v = (cyc < 4) ? 4'b0011 : 4'b1100;
                if (mode == 2 && cyc == 4) v = v | 4'b0010;
                in_data[0] = (cyc < 4) ? (16 * 0 + p) : (16 * 2 + p);
                in_data[1] = (cyc < 4) ? (16 * 1 + p) : (16 * 3 + p);
            end
            for (int k = 0; k < K; k++) begin
                if (v[k]) begin
                    if (mdl[k].size() < D) mdl[k].push_back(in_data[k % PE]);
                    else ovf_exp = 1'b1;
                end
            end
            in_valid = v;
            cyc++;
            full = 1'b1;
            for (int k = 0; k < K; k++) if (mdl[k].size() != D) full = 1'b0;
        end
        if (!full) chk("ld_timeout", 0, 1);
        // Cycle between the final capture edge and the state change.
        @(negedge clk);
        in_valid = '0;
        chk("lat_in_ready_still", in_ready, 1);
        chk("lat_out_valid_low", out_valid, 0);
        chk("ld_overflow", overflow, ovf_exp);
    endtask

    // bp 0: always ready, 1: pattern 1,0,0,1, 2: random ready.
    // stop_after > 0 returns right after that many transfers are requested.
    task automatic drain(input int bp, input bit inj, input int stop_after);
        int unsigned ed[$];
        int          ec[$];
        bit          el[$];
        int          n;
        int          cyc;
        bit          injected;
        bit          rdy;
        for (int k = 0; k < K; k++)
            for (int p = 0; p < mdl[k].size(); p++) begin
                ed.push_back(mdl[k][p]);
                ec.push_back(k);
                el.push_back(p == D - 1);
            end
        n = 0;
        cyc = 0;
        injected = 1'b0;
        while (ed.size() > 0 && cyc < 2000) begin
            @(negedge clk);
            in_valid = '0;
            chk("dr_out_valid", out_valid, 1);
            chk("dr_out_data", out_data, ed[0]);
            chk("dr_out_channel", out_channel, ec[0]);
            chk("dr_out_last", out_last, el[0]);
            chk("dr_in_ready", in_ready, 0);
            chk("dr_out_done", out_done, 0);
            case (bp)
                0:       rdy = 1'b1;
                1:       rdy = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            out_ready = rdy;
            if (inj && !injected && n == 5) begin
                in_valid = 4'b0100;
                ovf_exp  = 1'b1;
                injected = 1'b1;
            end
            if (rdy) begin
                void'(ed.pop_front());
                void'(ec.pop_front());
                void'(el.pop_front());
                n++;
            end
            cyc++;
            if (stop_after > 0 && n == stop_after) return;
        end
        if (ed.size() > 0) chk("dr_timeout", 0, 1);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = '0;
        chk("done_pulse", out_done, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_out_data", out_data, 0);
        chk("done_in_ready", in_ready, 0);
        @(negedge clk);
        chk("post_done_low", out_done, 0);
        chk("post_in_ready", in_ready, 1);
        chk("post_out_valid", out_valid, 0);
        chk("post_overflow", overflow, ovf_exp);
        clear_model();
    endtask

    initial begin
        // Reset and idle.
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_channel", out_channel, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_out_done", out_done, 0);
        chk("rst_overflow", overflow, 0);
        res_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("idle_in_ready", in_ready, 1);
            chk("idle_out_valid", out_valid, 0);
            chk("idle_out_done", out_done, 0);
            chk("idle_overflow", overflow, 0);
        end

        // Basic, then backpressure, then random content with random ready.
        load(0); drain(0, 1'b0, 0);
        load(0); drain(1, 1'b0, 0);
        for (int r = 0; r < 3; r++) begin
            load(1); drain(2, 1'b0, 0);
        end

        // Overflow in COLLECT and DRAIN, then confirm it stays set.
        load(2); drain(1, 1'b1, 0);
        load(1); drain(2, 1'b0, 0);

        // Reset in the middle of a drain.
        load(1); drain(0, 1'b0, 6);
        @(negedge clk);
        res_n = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_data", out_data, 0);
        chk("mid_rst_out_channel", out_channel, 0);
        chk("mid_rst_out_last", out_last, 0);
        chk("mid_rst_out_done", out_done, 0);
        chk("mid_rst_overflow", overflow, 0);
        ovf_exp = 1'b0;
        clear_model();
        @(negedge clk);
        res_n = 1'b1;
        load(1); drain(2, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
